uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Parametrised UART transmitter and successor to the fixed 4-way line select. It accepts a parallel word over a valid/ready handshake and generates the serial frame with its own baud timing. The frame is start, DATA_W data bits LSB first, optional even/odd parity, then 1 or 2 stop bits. It sits between the UART register front-end and the TX pin.

Parameters:
DATA_W, 8, data bits per frame (legal 5..9)
CLK_FREQ, 50_000_000, clk frequency in Hz
BAUD, 115200, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer division), must be >= 2
STOP_BITS, 1, stop bits per frame (legal 1 or 2)

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-low reset
tx_data  input  DATA_W  word to send, sampled on acceptance
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none; sampled on acceptance
tx_valid  input  1  word available
tx_ready  output  1  block can accept a word this cycle
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of last stop bit
tx_out  output  1  serial line, idle high

Behaviour:
- All outputs are registered. While rst=0 at a clk edge: tx_out=1, tx_ready=0, tx_busy=0, tx_done=0, FSM=IDLE, counters=0, shift register=0.
- Reset mid-frame aborts the frame. tx_out is 1 after the next edge and no tx_done is issued.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, tx_ready=1, tx_busy=0.
- Acceptance happens when tx_valid&tx_ready at an edge. At that edge the block latches tx_data, latches parity_mode, and computes the parity bit (even: XOR of data; odd: ~XOR). The FSM goes to START and tx_ready drops to 0.
- Latency: tx_out=0 in the first cycle after the accepting edge.
- Input changes after acceptance are ignored.
- Every bit lasts exactly BAUD_DIV clocks. The baud counter counts 0..BAUD_DIV-1, resets on each state/bit change, and raises a bit-end tick at BAUD_DIV-1.
- START to DATA on tick.
- DATA: tx_out = shift[0]. Shift right on each tick. The bit counter counts 0..DATA_W-1. After bit DATA_W-1, go to PARITY if the latched mode is even or odd, else go to STOP.
- PARITY: tx_out = latched parity bit, then STOP on tick.
- STOP: tx_out=1 for STOP_BITS*BAUD_DIV clocks. On the final tick, tx_done=1 for that cycle and the FSM goes to IDLE.
- No back-to-back acceptance at the final tick. IDLE lasts at least 1 clk between frames.
- Frame length from the accepting edge to the tx_done cycle, inclusive of the final tick: (1+DATA_W+P+STOP_BITS)*BAUD_DIV clocks, where P is 1 with parity and 0 without.
- tx_busy=1 in START, DATA, PARITY and STOP.
- tx_out is driven by a registered 4-way line select: IDLE/STOP give 1, START gives 0, DATA gives the data bit, PARITY gives the parity bit.
- Illegal parameters (DATA_W outside 5..9, STOP_BITS outside 1..2, BAUD_DIV<2) trigger an elaboration-time $error.

Decomposition:
- uart_pkg holds:
  - tx_state_e enum {IDLE, START, DATA, PARITY, STOP}
  - parity_mode_e {PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10}
  - line-level constants LINE_IDLE=1'b1, LINE_START=1'b0
  - line-select encoding {SEL_IDLE, SEL_START, SEL_DATA, SEL_PAR}
- global_pkg keeps TRUE/FALSE.
- One sub-module, uart_baud_gen, provides the counter and tick. Parameter BAUD_DIV; inputs clk, rst, clear; output tick.
- The FSM, shifter, parity and line select stay in uart_tx_serializer.

Test Plan:
- Reset mid-frame: assert rst=0 during DATA -> tx_out=1, tx_busy=0, tx_ready=0 the edge after; tx_ready=1 the first cycle after rst=1; no tx_done.
- Basic 8N1 at BAUD_DIV=10 (CLK_FREQ=1_000_000, BAUD=100_000), send 0xA5 with parity_mode=00 -> tx_out low 10 clk, then 1,0,1,0,0,1,0,1 at 10 clk each, high 10 clk; tx_done exactly 100 clk after acceptance.
- Even parity: 0x07, mode 01 -> parity bit 1, frame 110 clk. Odd parity: 0x07, mode 10 -> parity bit 0. Mode 11 -> no parity slot, 100 clk.
- Handshake: hold tx_valid=1 with 0x55 then 0x33 -> two frames; tx_ready=0 throughout each frame; at least 1 idle-high clk between frames. Change tx_data mid-frame -> transmitted bits unchanged.
- STOP_BITS=2, DATA_W=7, BAUD_DIV=4, send 0x7F mode 10 -> parity 0, line high for 8 clk at end, tx_done at clk 44.

Source files
------------

// File: rtl/global_pkg.sv
// Project-wide boolean constants.
package global_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

// File: rtl/uart_pkg.sv
// Shared UART types: transmitter states, parity modes, line levels and line-select codes.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  typedef enum logic [1:0] {SEL_IDLE, SEL_START, SEL_DATA, SEL_PAR} line_sel_e;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last clock of each bit.
module uart_baud_gen #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(BAUD_DIV);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear) r_cnt <= '0;
    else if (tick)     r_cnt <= '0;
    else               r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: valid/ready word intake, start/data/parity/stop framing,
// registered 4-way line select driving the TX pin.
module uart_tx_serializer
  import uart_pkg::*;
  import global_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        parity_mode,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_out
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BCW      = $clog2(DATA_W);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_serializer: DATA_W must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_serializer: CLK_FREQ/BAUD must be >= 2");
  end

  tx_state_e         r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [BCW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic              r_par_bit, w_par_bit_nxt;
  logic              r_par_en, w_par_en_nxt;
  logic              r_tx_out, r_ready, r_busy, r_done;
  logic              w_accept, w_tick, w_done_nxt, w_line;
  line_sel_e         w_sel;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (r_state == IDLE),
    .tick  (w_tick)
  );

  // r_ready is only high in IDLE, so it doubles as the acceptance gate.
  assign w_accept = tx_valid && r_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_bit_nxt = r_par_bit;
    w_par_en_nxt  = r_par_en;
    w_done_nxt    = FALSE;
    unique case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt   = START;
        w_shift_nxt   = tx_data;
        w_bit_cnt_nxt = '0;
        w_par_en_nxt  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
        w_par_bit_nxt = (parity_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
      end
      START: if (w_tick) w_state_nxt = DATA;
      DATA: if (w_tick) begin
        w_shift_nxt = r_shift >> 1;
        if (r_bit_cnt == BCW'(DATA_W - 1)) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = r_par_en ? PARITY : STOP;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
        end
      end
      PARITY: if (w_tick) w_state_nxt = STOP;
      STOP: if (w_tick) begin
        if (r_bit_cnt == BCW'(STOP_BITS - 1)) begin
          w_state_nxt   = IDLE;
          w_bit_cnt_nxt = '0;
          w_done_nxt    = TRUE;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level is chosen from the next state so tx_out lines up with it.
  always_comb begin
    w_sel = SEL_IDLE;
    unique case (w_state_nxt)
      START:   w_sel = SEL_START;
      DATA:    w_sel = SEL_DATA;
      PARITY:  w_sel = SEL_PAR;
      default: w_sel = SEL_IDLE;
    endcase
    unique case (w_sel)
      SEL_START: w_line = LINE_START;
      SEL_DATA:  w_line = w_shift_nxt[0];
      SEL_PAR:   w_line = w_par_bit_nxt;
      default:   w_line = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_bit <= FALSE;
      r_par_en  <= FALSE;
      r_tx_out  <= LINE_IDLE;
      r_ready   <= FALSE;
      r_busy    <= FALSE;
      r_done    <= FALSE;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_par_en  <= w_par_en_nxt;
      r_tx_out  <= w_line;
      r_ready   <= (w_state_nxt == IDLE);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
    end
  end

  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;
  assign tx_out   = r_tx_out;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: 8x1 UART at BAUD_DIV=10 and 7-bit/2-stop UART at BAUD_DIV=4.
module tb_uart_tx_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d0_data = '0;
  logic [1:0] d0_mode = '0;
  logic       d0_valid = 1'b0;
  logic       d0_ready, d0_busy, d0_done, d0_out;
  logic [6:0] d1_data = '0;
  logic [1:0] d1_mode = '0;
  logic       d1_valid = 1'b0;
  logic       d1_ready, d1_busy, d1_done, d1_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_W(8), .CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_data(d0_data), .parity_mode(d0_mode), .tx_valid(d0_valid),
    .tx_ready(d0_ready), .tx_busy(d0_busy), .tx_done(d0_done), .tx_out(d0_out));

  uart_tx_serializer #(.DATA_W(7), .CLK_FREQ(400_000), .BAUD(100_000), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx_data(d1_data), .parity_mode(d1_mode), .tx_valid(d1_valid),
    .tx_ready(d1_ready), .tx_busy(d1_busy), .tx_done(d1_done), .tx_out(d1_out));

  typedef struct {
    int         which;
    logic [8:0] data;
    logic [1:0] mode;
    logic [8:0] nxt_data;
    logic [1:0] nxt_mode;
    bit         keep;
    bit         has_par;
    bit         par_bit;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic [8:0] data, input logic [1:0] mode, input logic vld);
    if (w == 0) begin
      d0_data = data[7:0]; d0_mode = mode; d0_valid = vld;
    end else begin
      d1_data = data[6:0]; d1_mode = mode; d1_valid = vld;
    end
  endtask

  task automatic sample(input int w, output logic o, output logic r, output logic b, output logic d);
    if (w == 0) begin
      o = d0_out; r = d0_ready; b = d0_busy; d = d0_done;
    end else begin
      o = d1_out; r = d1_ready; b = d1_busy; d = d1_done;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   bd, dw, sb, waited, bad_line, bad_stat;
    logic o, r, b, d;
    logic q[$];
    bd = (v.which == 0) ? 10 : 4;
    dw = (v.which == 0) ? 8 : 7;
    sb = (v.which == 0) ? 1 : 2;
    q.delete();
    repeat (bd) q.push_back(1'b0);
    for (int i = 0; i < dw; i++) repeat (bd) q.push_back(v.data[i]);
    if (v.has_par) repeat (bd) q.push_back(v.par_bit);
    repeat (sb * bd) q.push_back(1'b1);

    @(negedge clk);
    drive(v.which, v.data, v.mode, 1'b1);
    waited = 0;
    sample(v.which, o, r, b, d);
    while (r !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
      sample(v.which, o, r, b, d);
    end
    checks++;
    if (waited >= 50) begin
      errors++;
      $display("FAIL accept vec%0d: tx_ready stayed %b, expected 1", idx, r);
      drive(v.which, 9'h0, 2'b00, 1'b0);
      return;
    end
    @(posedge clk); #1;
    // Scramble inputs right after acceptance; the frame must not notice.
    drive(v.which, v.nxt_data, v.nxt_mode, v.keep);

    bad_line = 0;
    bad_stat = 0;
    for (int j = 0; j < v.exp_len; j++) begin
      sample(v.which, o, r, b, d);
      if (o !== q[j]) bad_line++;
      if (r !== 1'b0 || b !== 1'b1 || d !== 1'b0) bad_stat++;
      @(posedge clk); #1;
    end
    sample(v.which, o, r, b, d);

    checks++;
    if (bad_line != 0) begin
      errors++;
      $display("FAIL line vec%0d: %0d cycles differ from frame, expected 0", idx, bad_line);
    end
    checks++;
    if (bad_stat != 0) begin
      errors++;
      $display("FAIL status vec%0d: %0d cycles with ready/busy/done wrong, expected 0", idx, bad_stat);
    end
    checks++;
    if ({d, r, b, o} !== 4'b1101) begin
      errors++;
      $display("FAIL end vec%0d: done,ready,busy,out=%b%b%b%b at clk %0d, expected 1101",
               idx, d, r, b, o, v.exp_len);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   bad_done, bad_out;
    logic o, r, b, d;

    vecs[0] = '{0, 9'h0A5, 2'b00, 9'h05A, 2'b01, 1'b0, 1'b0, 1'b0, 100};
    vecs[1] = '{0, 9'h007, 2'b01, 9'h0F8, 2'b00, 1'b0, 1'b1, 1'b1, 110};
    vecs[2] = '{0, 9'h007, 2'b10, 9'h000, 2'b01, 1'b0, 1'b1, 1'b0, 110};
    vecs[3] = '{0, 9'h007, 2'b11, 9'h0FF, 2'b01, 1'b0, 1'b0, 1'b0, 100};
    vecs[4] = '{0, 9'h055, 2'b00, 9'h033, 2'b00, 1'b1, 1'b0, 1'b0, 100};
    vecs[5] = '{0, 9'h033, 2'b00, 9'h0C3, 2'b10, 1'b0, 1'b0, 1'b0, 100};
    vecs[6] = '{1, 9'h07F, 2'b10, 9'h000, 2'b01, 1'b0, 1'b1, 1'b0, 44};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst d0 tx_out", d0_out, 1'b1);
    chk("rst d0 tx_ready", d0_ready, 1'b0);
    chk("rst d0 tx_busy", d0_busy, 1'b0);
    chk("rst d0 tx_done", d0_done, 1'b0);
    chk("rst d1 tx_out", d1_out, 1'b1);
    chk("rst d1 tx_ready", d1_ready, 1'b0);
    chk("rst d1 tx_busy", d1_busy, 1'b0);
    chk("rst d1 tx_done", d1_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post-rst d0 tx_ready", d0_ready, 1'b1);
    chk("post-rst d1 tx_ready", d1_ready, 1'b1);

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Reset in the middle of the data phase of an all-zero word.
    @(negedge clk);
    drive(0, 9'h000, 2'b00, 1'b1);
    @(posedge clk); #1;
    drive(0, 9'h000, 2'b00, 1'b0);
    repeat (25) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst tx_out", d0_out, 1'b1);
    chk("midrst tx_busy", d0_busy, 1'b0);
    chk("midrst tx_ready", d0_ready, 1'b0);
    chk("midrst tx_done", d0_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst release tx_ready", d0_ready, 1'b1);
    bad_done = 0;
    bad_out  = 0;
    for (int j = 0; j < 120; j++) begin
      sample(0, o, r, b, d);
      if (d !== 1'b0) bad_done++;
      if (o !== 1'b1) bad_out++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad_done != 0 || bad_out != 0) begin
      errors++;
      $display("FAIL midrst aftermath: %0d done cycles, %0d low-line cycles, expected 0 and 0",
               bad_done, bad_out);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
